// File: rtl/md5_arith_pkg.sv
// Shared arithmetic definitions for the MD5 round-unwind datapath blocks.
package md5_arith_pkg;

    localparam int WORD_W  = 32;
    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nslice(input int width, input int slice);
        return width / slice;
    endfunction

endpackage

// File: rtl/sub32_serial_slice_sub.sv
// Combinational W-bit subtract slice: d = x - y - bin, bout set on underflow.
module slice_sub
    import md5_arith_pkg::*;
#(
    parameter int W = SLICE_W
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    logic [W:0] sum;

    // Two's-complement form: carry-out of x + ~y + !bin is the inverse of borrow.
    assign sum  = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, ~bin};
    assign d    = sum[W-1:0];
    assign bout = ~sum[W];

endmodule

// File: rtl/sub32_serial.sv
// Serial modular subtractor, one SLICE-bit chunk per cycle, LSB chunk first.
// Define SUB32_SERIAL_ADD_MODE_EN to add an 'op' port selecting a + b.
module sub32_serial
    import md5_arith_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int SLICE = SLICE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SUB32_SERIAL_ADD_MODE_EN
    input  logic             op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int NSLICE = nslice(WIDTH, SLICE);
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NSLICE - 1);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic             brw;
    logic             op_q;
    logic             op_in;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             accept;
    logic             last;
    logic [SLICE-1:0] a_s;
    logic [SLICE-1:0] b_s;
    logic [SLICE-1:0] y_s;
    logic [SLICE-1:0] d_s;
    logic             bout;

`ifdef SUB32_SERIAL_ADD_MODE_EN
    assign op_in = op;
`else
    assign op_in = 1'b0;
`endif

    assign accept = in_valid && (state == IDLE);
    assign last   = (idx == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Addition reuses the subtract slice: feeding ~b turns x + ~y into x + b,
    // and the registered bit holds the inverted carry in that mode.
    always_comb begin
        a_s = a_q[idx*SLICE +: SLICE];
        b_s = b_q[idx*SLICE +: SLICE];
        y_s = op_q ? ~b_s : b_s;
    end

    slice_sub #(
        .W(SLICE)
    ) u_slice (
        .x   (a_s),
        .y   (y_s),
        .bin (brw),
        .d   (d_s),
        .bout(bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= 1'b0;
            idx    <= '0;
            brw    <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else if (accept) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op_in;
            idx  <= '0;
            // Add mode starts with carry-in 0, i.e. an inverted "borrow" of 1.
            brw  <= op_in;
        end else if (state == BUSY) begin
            diff[idx*SLICE +: SLICE] <= d_s;
            brw <= bout;
            idx <= idx + 1'b1;
            if (last) begin
                borrow <= op_q ? ~bout : bout;
            end
        end
    end

endmodule

// File: tb/tb_sub32_serial.sv
// Self-checking bench for sub32_serial against a plain-arithmetic reference model.
module tb_sub32_serial;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        borrow;

    int n_checks;
    int n_fail;

    sub32_serial dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a_i),
        .b        (b_i),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .borrow   (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: unsigned wrap-around subtraction.
    function automatic logic [31:0] ref_diff(input logic [31:0] x, input logic [31:0] y);
        return x - y;
    endfunction

    function automatic logic ref_borrow(input logic [31:0] x, input logic [31:0] y);
        return x < y;
    endfunction

    // Drives one operation through both handshakes; lat = edges from accept to out_valid, -1 on timeout.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] d, output logic br, output int lat);
        int n;
        @(negedge clk);
        a_i = av;
        b_i = bv;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_i = $urandom;
        b_i = $urandom;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        d  = diff;
        br = borrow;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        if (lat >= 50) lat = -1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (diff !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_diff: got %h expected 00000000", diff);
        end
        n_checks++;
        if (borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_borrow: got %b expected 0", borrow);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [31:0] d;
        logic        br;
        int          lat;
        va[0] = 32'h00000005; vb[0] = 32'h00000003;
        va[1] = 32'h00000000; vb[1] = 32'h00000001;
        va[2] = 32'h12345678; vb[2] = 32'h12345678;
        va[3] = 32'h01000000; vb[3] = 32'h000000FF;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], d, br, lat);
            n_checks++;
            if (lat !== 4) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d expected 4", i, lat);
            end
            n_checks++;
            if (d !== ref_diff(va[i], vb[i])) begin
                n_fail++;
                $display("FAIL directed_diff[%0d]: got %h expected %h", i, d, ref_diff(va[i], vb[i]));
            end
            n_checks++;
            if (br !== ref_borrow(va[i], vb[i])) begin
                n_fail++;
                $display("FAIL directed_borrow[%0d]: got %b expected %b", i, br, ref_borrow(va[i], vb[i]));
            end
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL directed_in_ready_after[%0d]: got %b expected 1", i, in_ready);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] d;
        logic        br;
        int          lat;
        for (int i = 0; i < 30; i++) begin
            av = $urandom;
            bv = ($urandom_range(0, 4) == 0) ? av : 32'($urandom);
            if (i % 7 == 3) bv = av + 32'd1;
            do_op(av, bv, d, br, lat);
            n_checks++;
            if (d !== ref_diff(av, bv) || br !== ref_borrow(av, bv) || lat !== 4) begin
                n_fail++;
                $display("FAIL random[%0d] a=%h b=%h: got diff=%h borrow=%b lat=%0d expected diff=%h borrow=%b lat=4",
                         i, av, bv, d, br, lat, ref_diff(av, bv), ref_borrow(av, bv));
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] av;
        logic [31:0] bv;
        int          n;
        int          seen;
        av = 32'h00000003;
        bv = 32'hFFFFFFF0;
        @(negedge clk);
        a_i = av;
        b_i = bv;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (n !== 4) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d expected 4", n);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== ref_diff(av, bv) || borrow !== ref_borrow(av, bv)) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got out_valid=%b in_ready=%b diff=%h borrow=%b expected 1 0 %h %b",
                         i, out_valid, in_ready, diff, borrow, ref_diff(av, bv), ref_borrow(av, bv));
            end
            in_valid = (i % 2 == 0);
            a_i = $urandom;
            b_i = $urandom;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL bp_no_spurious: got %0d out_valid cycles expected 0", seen);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        logic        br;
        int          lat;
        int          n;
        int          seen;
        @(negedge clk);
        a_i = 32'h89ABCDEF;
        b_i = 32'h12345678;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 32'h0 || borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_values: got in_ready=%b out_valid=%b diff=%h borrow=%b expected 1 0 00000000 0",
                     in_ready, out_valid, diff, borrow);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL midreset_no_out_valid: got %0d cycles expected 0", seen);
        end
        do_op(32'd9, 32'd4, d, br, lat);
        n_checks++;
        if (d !== 32'h00000005 || br !== 1'b0 || lat !== 4) begin
            n_fail++;
            $display("FAIL midreset_next_op: got diff=%h borrow=%b lat=%0d expected 00000005 0 4", d, br, lat);
        end
    endtask

    task automatic test_back_to_back;
        int          acc[$];
        logic [31:0] av;
        logic [31:0] bv;
        int          nres;
        av = 32'hCAFEBABE;
        bv = 32'hDEADBEEF;
        nres = 0;
        @(posedge clk);
        #1;
        a_i = av;
        b_i = bv;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (in_ready) acc.push_back(c);
            if (out_valid) begin
                nres++;
                n_checks++;
                if (diff !== ref_diff(av, bv) || borrow !== ref_borrow(av, bv)) begin
                    n_fail++;
                    $display("FAIL b2b_result: got diff=%h borrow=%b expected %h %b",
                             diff, borrow, ref_diff(av, bv), ref_borrow(av, bv));
                end
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (acc.size() < 3) begin
            n_fail++;
            $display("FAIL b2b_accepts: got %0d accepts expected at least 3", acc.size());
        end else if (acc[1] - acc[0] !== 6 || acc[2] - acc[1] !== 6) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d,%0d expected 6,6", acc[1] - acc[0], acc[2] - acc[1]);
        end
        n_checks++;
        if (nres < 3) begin
            n_fail++;
            $display("FAIL b2b_results: got %0d results expected at least 3", nres);
        end
        repeat (8) @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_i       = '0;
        b_i       = '0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
